uno_glyph_renderer: RTL and testbench
=====================================

// Module: uno_glyph_renderer
// PURPOSE
//  Pipelined, parametrised UNO card-face glyph renderer for the DE2-115 VGA path.
//  Draws one of NUM_GLYPHS card glyphs (0-9 default) at (x_pin,y_pin), integer-scaled, in one of 4 card colours.
//  Sits between the VGA timing counters and the per-layer RGB mux; one instance per on-screen card.
//  Adds per-frame latching of its inputs (no tearing) and a frame-counted highlight blink.
// PARAMETERS
//  X_WIDTH      30  glyph bitmap width, pixels (unscaled)
//  Y_WIDTH      50  glyph bitmap height, pixels (unscaled)
//  NUM_GLYPHS   10  number of glyphs in ROM; glyph_sel >= NUM_GLYPHS renders blank face
//  SCALE_LOG2   0   on-screen scale = 2**SCALE_LOG2 (legal 0..2)
//  BLINK_FRAMES 15  frames per blink half-period (>=1)
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous, active-high reset
//  frame_start  in   1   1-cycle pulse at start of vertical blank
//  pix_valid_i  in   1   x_cnt/y_cnt denote an active pixel this cycle
//  x_cnt        in   10  current pixel column
//  y_cnt        in   10  current pixel row
//  x_pin        in   10  card top-left column (latched at frame_start)
//  y_pin        in   10  card top-left row (latched at frame_start)
//  glyph_sel    in   4   glyph index (latched at frame_start)
//  color        in   2   card_color_e: 00 red, 01 yellow, 10 green, 11 blue (latched)
//  highlight    in   1   request blink (latched at frame_start)
//  pix_valid_o  out  1   pix_valid_i delayed 2 cycles
//  hit          out  1   pixel lies inside card box (aligned with rgb)
//  r_data       out  8   red
//  g_data       out  8   green
//  b_data       out  8   blue
// BEHAVIOUR
//  - Reset: all outputs 0; shadow regs x/y_pin=0, glyph=0, color=RED, highlight=0; FSM BL_OFF, frame cnt 0.
//  - Shadow regs load only in the cycle frame_start=1; inputs ignored otherwise.
//  - Box: W=X_WIDTH<<SCALE_LOG2, H=Y_WIDTH<<SCALE_LOG2; inside iff x_pin<=x_cnt<x_pin+W and same for y,
//    with half-open bounds. Sums computed in 11 bits: a box past 1023 clips, never wraps.
//  - Latency exactly 2 clk. Stage 1 registers inside flag, row=(y_cnt-y_pin)>>SCALE_LOG2,
//    col=(x_cnt-x_pin)>>SCALE_LOG2, valid. Stage 2 registers ROM bit p plus colour map.
//  - ROM bit order: row 0 = top; col 0 = leftmost pixel (MSB of row word). p=1 is white face, p=0 is ink.
//  - Colour map: RED {FF, p?FF:00, p?FF:00}; YELLOW {FF, p?FF:C0, p?FF:00};
//    GREEN {p?FF:00, p?FF:80, p?FF:00}; BLUE {p?FF:00, p?FF:00, FF}.
//  - Outside box or pix_valid low: rgb=0, hit=0. glyph_sel>=NUM_GLYPHS: p=1 (blank white face).
//  - Blink FSM (advances only on frame_start): BL_OFF -> BL_SHOW when latched highlight=1;
//    BL_SHOW <-> BL_HIDE after BLINK_FRAMES frames each; any state -> BL_OFF when latched highlight=0.
//    Frame counter clears on every state change.
//  - BL_HIDE: p is inverted before the colour map. BL_OFF/BL_SHOW: normal.
//  - Simultaneous frame_start and active pixel: that pixel uses the old shadow values.
//  - rst mid-frame: pipeline flushed; outputs 0 from the next cycle until new valid pixels reach stage 2.
// CONFIGURATION
//  UNO_GLYPH_BLINK_EN defined: blink FSM as above.
//  UNO_GLYPH_BLINK_EN undefined: no FSM or counter; highlight is ignored; p is never inverted.
// STRUCTURE
//  uno_render_pkg: card_color_e enum, rgb_t struct {r,g,b}, ink constants (C0 yellow, 80 green), blink_state_e.
//  Sub-module uno_glyph_rom: combinational lookup of [glyph][row][col] -> bit;
//    contains all NUM_GLYPHS bitmaps (X_WIDTH x Y_WIDTH each); out-of-range glyph returns 1.
//  Top: shadow regs, 2-stage pipeline, colour map, blink FSM.
// TESTING
//  1. SCALE_LOG2=0, pin=(100,50), glyph 2, RED, frame_start, then raster sweep:
//     hit=1 exactly for x 100..129 and y 50..99; pixel (100,50) gives FFFFFF 2 cycles later; x=130 gives hit=0.
//  2. color=YELLOW, pixel on an ink bit -> {FF,C0,00}; color=GREEN same pixel -> {00,80,00}.
//  3. Change x_pin mid-frame without frame_start -> output unchanged; after frame_start the new position is used.
//  4. SCALE_LOG2=1, pin=(1000,0) -> box clips at x=1023; no hit at x=0..40 (no wrap); each ROM bit covers 2x2 pixels.
//  5. BLINK_EN, BLINK_FRAMES=2, highlight=1: glyph normal for frames 1-2, inverted for 3-4, normal for 5-6;
//     drop highlight -> normal after the next frame_start.
//  6. glyph_sel=12 -> whole box face colour white (FFFFFF); rst asserted mid-line -> rgb/hit/pix_valid_o 0 the next cycle.

Source files
------------

// File: rtl/uno_render_pkg.sv
// Shared types for the UNO card glyph renderer: card colours, pixel colour
// struct, ink intensities and blink states, plus the card colour map.
package uno_render_pkg;

    typedef enum logic [1:0] {
        COL_RED    = 2'b00,
        COL_YELLOW = 2'b01,
        COL_GREEN  = 2'b10,
        COL_BLUE   = 2'b11
    } card_color_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        BL_OFF  = 2'b00,
        BL_SHOW = 2'b01,
        BL_HIDE = 2'b10
    } blink_state_e;

    // Partial-intensity green channel used for yellow and green card ink.
    localparam logic [7:0] INK_YELLOW_G = 8'hC0;
    localparam logic [7:0] INK_GREEN_G  = 8'h80;

    // p=1 is the white card face, p=0 is the glyph ink in the card colour.
    function automatic rgb_t color_map(input card_color_e c, input logic p);
        rgb_t o;
        case (c)
            COL_RED: begin
                o.r = 8'hFF;
                o.g = p ? 8'hFF : 8'h00;
                o.b = p ? 8'hFF : 8'h00;
            end
            COL_YELLOW: begin
                o.r = 8'hFF;
                o.g = p ? 8'hFF : INK_YELLOW_G;
                o.b = p ? 8'hFF : 8'h00;
            end
            COL_GREEN: begin
                o.r = p ? 8'hFF : 8'h00;
                o.g = p ? 8'hFF : INK_GREEN_G;
                o.b = p ? 8'hFF : 8'h00;
            end
            default: begin
                o.r = p ? 8'hFF : 8'h00;
                o.g = p ? 8'hFF : 8'h00;
                o.b = 8'hFF;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/uno_glyph_renderer_if.sv
// Pixel-stream / card-control bundle between the VGA timing logic and one
// glyph renderer instance. master = timing side, slave = renderer.
interface uno_glyph_renderer_if;
    import uno_render_pkg::*;

    logic        frame_start;
    logic        pix_valid_i;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic [9:0]  x_pin;
    logic [9:0]  y_pin;
    logic [3:0]  glyph_sel;
    card_color_e color;
    logic        highlight;
    logic        pix_valid_o;
    logic        hit;
    logic [7:0]  r_data;
    logic [7:0]  g_data;
    logic [7:0]  b_data;

    modport master (
        output frame_start, pix_valid_i, x_cnt, y_cnt, x_pin, y_pin,
               glyph_sel, color, highlight,
        input  pix_valid_o, hit, r_data, g_data, b_data
    );

    modport slave (
        input  frame_start, pix_valid_i, x_cnt, y_cnt, x_pin, y_pin,
               glyph_sel, color, highlight,
        output pix_valid_o, hit, r_data, g_data, b_data
    );
endinterface

// File: rtl/uno_glyph_renderer_rom.sv
// Glyph bitmap store for the renderer. Digits are drawn as seven-segment
// shapes whose geometry scales with the bitmap size; glyph indices 10 and up
// (inside NUM_GLYPHS) repeat the digit set. Out-of-range lookups read as face.
module uno_glyph_rom
    import uno_render_pkg::*;
#(
    parameter int X_WIDTH    = 30,
    parameter int Y_WIDTH    = 50,
    parameter int NUM_GLYPHS = 10,
    parameter int ROW_W      = 6,
    parameter int COL_W      = 5
) (
    input  logic [3:0]       glyph,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic             pix
);
    localparam int DEPTH = NUM_GLYPHS * Y_WIDTH;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Segment geometry: horizontal span XL..XR, stroke thickness TH,
    // top/middle/bottom stroke rows YT/YM/YB.
    localparam int XL = X_WIDTH / 4;
    localparam int XR = X_WIDTH - 1 - X_WIDTH / 4;
    localparam int TH = (X_WIDTH / 8 > 0) ? X_WIDTH / 8 : 1;
    localparam int YT = Y_WIDTH / 10;
    localparam int YB = Y_WIDTH - 1 - Y_WIDTH / 10;
    localparam int YM = Y_WIDTH / 2;

    localparam logic [X_WIDTH-1:0] LSB_ONE = X_WIDTH'(1);

    // Segment masks {a,b,c,d,e,f,g} for the digits 0..9.
    function automatic logic [6:0] seg_mask(input int g);
        logic [6:0] s;
        case (g % 10)
            0:       s = 7'b1111110;
            1:       s = 7'b0110000;
            2:       s = 7'b1101101;
            3:       s = 7'b1111001;
            4:       s = 7'b0110011;
            5:       s = 7'b1011011;
            6:       s = 7'b1011111;
            7:       s = 7'b1110000;
            8:       s = 7'b1111111;
            default: s = 7'b1111011;
        endcase
        return s;
    endfunction

    function automatic logic ink_at(input logic [6:0] seg, input int r, input int c);
        logic span_h, left_v, right_v, upper, lower;
        span_h  = (c >= XL) && (c <= XR);
        left_v  = (c >= XL) && (c < XL + TH);
        right_v = (c > XR - TH) && (c <= XR);
        upper   = (r >= YT) && (r <= YM);
        lower   = (r >= YM) && (r <= YB);
        return (seg[6] && span_h && (r >= YT) && (r < YT + TH))
            || (seg[5] && right_v && upper)
            || (seg[4] && right_v && lower)
            || (seg[3] && span_h && (r > YB - TH) && (r <= YB))
            || (seg[2] && left_v && lower)
            || (seg[1] && left_v && upper)
            || (seg[0] && span_h && (r >= YM - 1) && (r < YM - 1 + TH));
    endfunction

    // Row word: column 0 is the MSB; ink pixels are 0, face pixels are 1.
    function automatic logic [X_WIDTH-1:0] glyph_row(input int g, input int r);
        logic [X_WIDTH-1:0] w;
        logic [6:0]         seg;
        seg = seg_mask(g);
        w   = '1;
        for (int c = 0; c < X_WIDTH; c++) begin
            if (ink_at(seg, r, c)) begin
                w = w & ~(LSB_ONE << (X_WIDTH - 1 - c));
            end
        end
        return w;
    endfunction

    logic [X_WIDTH-1:0] rom [DEPTH];

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom_row
        assign rom[gi] = glyph_row(gi / Y_WIDTH, gi % Y_WIDTH);
    end

    logic [IDX_W-1:0] idx;

    // Bit lookup; anything outside the stored bitmaps reads as white face.
    always_comb begin
        idx = '0;
        pix = 1'b1;
        if ((int'(glyph) < NUM_GLYPHS) && (int'(row) < Y_WIDTH) && (int'(col) < X_WIDTH)) begin
            idx = IDX_W'(int'(glyph) * Y_WIDTH + int'(row));
            pix = |(rom[idx] & (LSB_ONE << (X_WIDTH - 1 - int'(col))));
        end
    end

endmodule

// File: rtl/uno_glyph_renderer.sv
// UNO card-face glyph renderer: frame-latched card parameters, 2-cycle pixel
// pipeline (box/row/col, then ROM bit + colour map). Optional highlight blink
// is compiled in with UNO_GLYPH_BLINK_EN.
module uno_glyph_renderer
    import uno_render_pkg::*;
#(
    parameter int X_WIDTH      = 30,
    parameter int Y_WIDTH      = 50,
    parameter int NUM_GLYPHS   = 10,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    uno_glyph_renderer_if.slave  bus
);
    localparam int BOX_W = X_WIDTH << SCALE_LOG2;
    localparam int BOX_H = Y_WIDTH << SCALE_LOG2;
    localparam int COL_W = (X_WIDTH > 1) ? $clog2(X_WIDTH) : 1;
    localparam int ROW_W = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;

    // Shadow copies of the card parameters
    logic [9:0]  x_pin_q, x_pin_d, y_pin_q, y_pin_d;
    logic [3:0]  glyph_q, glyph_d;
    card_color_e color_q, color_d;

    // Stage 1
    logic             s1_valid_q, s1_valid_d;
    logic             s1_inside_q, s1_inside_d;
    logic [ROW_W-1:0] s1_row_q, s1_row_d;
    logic [COL_W-1:0] s1_col_q, s1_col_d;
    logic [3:0]       s1_glyph_q, s1_glyph_d;
    card_color_e      s1_color_q, s1_color_d;
    logic             s1_hide_q, s1_hide_d;

    // Stage 2 (outputs)
    logic pix_valid_q, pix_valid_d;
    logic hit_q, hit_d;
    rgb_t rgb_q, rgb_d;

    logic        hide_active;
    logic        rom_pix;
    logic [10:0] x_end, y_end;
    logic [9:0]  dx, dy;
    logic        in_box;

    // Card parameters change only on frame_start so a frame never tears.
    always_comb begin
        x_pin_d = x_pin_q;
        y_pin_d = y_pin_q;
        glyph_d = glyph_q;
        color_d = color_q;
        if (bus.frame_start) begin
            x_pin_d = bus.x_pin;
            y_pin_d = bus.y_pin;
            glyph_d = bus.glyph_sel;
            color_d = bus.color;
        end
    end

    // Stage 1: box test in 11 bits (clips past column/row 1023) and glyph
    // coordinates. Glyph, colour and blink phase travel with the pixel so a
    // pixel coinciding with frame_start is rendered with the old settings.
    always_comb begin
        x_end       = {1'b0, x_pin_q} + 11'(BOX_W);
        y_end       = {1'b0, y_pin_q} + 11'(BOX_H);
        dx          = bus.x_cnt - x_pin_q;
        dy          = bus.y_cnt - y_pin_q;
        in_box      = (bus.x_cnt >= x_pin_q) && ({1'b0, bus.x_cnt} < x_end)
                   && (bus.y_cnt >= y_pin_q) && ({1'b0, bus.y_cnt} < y_end);
        s1_valid_d  = bus.pix_valid_i;
        s1_inside_d = bus.pix_valid_i && in_box;
        s1_row_d    = '0;
        s1_col_d    = '0;
        if (s1_inside_d) begin
            s1_row_d = ROW_W'(dy >> SCALE_LOG2);
            s1_col_d = COL_W'(dx >> SCALE_LOG2);
        end
        s1_glyph_d  = glyph_q;
        s1_color_d  = color_q;
        s1_hide_d   = hide_active;
    end

    uno_glyph_rom #(
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH),
        .NUM_GLYPHS (NUM_GLYPHS),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_rom (
        .glyph (s1_glyph_q),
        .row   (s1_row_q),
        .col   (s1_col_q),
        .pix   (rom_pix)
    );

    // Stage 2: ROM bit (inverted during the hide phase) through the colour map.
    always_comb begin
        pix_valid_d = s1_valid_q;
        hit_d       = s1_inside_q;
        rgb_d       = '0;
        if (s1_inside_q) begin
            rgb_d = color_map(s1_color_q, rom_pix ^ s1_hide_q);
        end
    end

    // Shadow and pipeline registers; reset flushes everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_pin_q     <= '0;
            y_pin_q     <= '0;
            glyph_q     <= '0;
            color_q     <= COL_RED;
            s1_valid_q  <= 1'b0;
            s1_inside_q <= 1'b0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            s1_glyph_q  <= '0;
            s1_color_q  <= COL_RED;
            s1_hide_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            rgb_q       <= '0;
        end else begin
            x_pin_q     <= x_pin_d;
            y_pin_q     <= y_pin_d;
            glyph_q     <= glyph_d;
            color_q     <= color_d;
            s1_valid_q  <= s1_valid_d;
            s1_inside_q <= s1_inside_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            s1_glyph_q  <= s1_glyph_d;
            s1_color_q  <= s1_color_d;
            s1_hide_q   <= s1_hide_d;
            pix_valid_q <= pix_valid_d;
            hit_q       <= hit_d;
            rgb_q       <= rgb_d;
        end
    end

`ifdef UNO_GLYPH_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    logic             highlight_q, highlight_d;
    blink_state_e     blink_state_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             hide_q;

    // The FSM sees the highlight value being latched at this frame_start.
    always_comb begin
        highlight_d = bus.frame_start ? bus.highlight : highlight_q;
    end

    // Blink sequencer: steps once per frame, hide_q is its registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            highlight_q   <= 1'b0;
            blink_state_q <= BL_OFF;
            frame_cnt_q   <= '0;
            hide_q        <= 1'b0;
        end else begin
            highlight_q <= highlight_d;
            if (bus.frame_start) begin
                if (!highlight_d) begin
                    blink_state_q <= BL_OFF;
                    frame_cnt_q   <= '0;
                    hide_q        <= 1'b0;
                end else begin
                    case (blink_state_q)
                        BL_OFF: begin
                            blink_state_q <= BL_SHOW;
                            frame_cnt_q   <= '0;
                            hide_q        <= 1'b0;
                        end
                        BL_SHOW: begin
                            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                                blink_state_q <= BL_HIDE;
                                frame_cnt_q   <= '0;
                                hide_q        <= 1'b1;
                            end else begin
                                frame_cnt_q   <= frame_cnt_q + 1'b1;
                            end
                        end
                        BL_HIDE: begin
                            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                                blink_state_q <= BL_SHOW;
                                frame_cnt_q   <= '0;
                                hide_q        <= 1'b0;
                            end else begin
                                frame_cnt_q   <= frame_cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            blink_state_q <= BL_OFF;
                            frame_cnt_q   <= '0;
                            hide_q        <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign hide_active = hide_q;
`else
    // Without the blink feature the highlight request has no effect.
    logic unused_highlight;
    assign unused_highlight = bus.highlight;
    assign hide_active      = 1'b0;
`endif

    assign bus.pix_valid_o = pix_valid_q;
    assign bus.hit         = hit_q;
    assign bus.r_data      = rgb_q.r;
    assign bus.g_data      = rgb_q.g;
    assign bus.b_data      = rgb_q.b;

endmodule

// File: tb/tb_uno_glyph_renderer.sv
// Directed bench for uno_glyph_renderer: instance A at scale 1x, instance B at
// scale 2x, both fed the same stimulus. Blink expectations follow
// UNO_GLYPH_BLINK_EN.
module tb_uno_glyph_renderer;
    import uno_render_pkg::*;

`ifdef UNO_GLYPH_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [23:0] WHITE    = 24'hFFFFFF;
    localparam logic [23:0] RED_INK  = 24'hFF0000;
    localparam logic [23:0] YEL_INK  = 24'hFFC000;
    localparam logic [23:0] GRN_INK  = 24'h008000;
    localparam logic [23:0] BLU_INK  = 24'h0000FF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fs_i = 1'b0;
    logic       pv_i = 1'b0;
    logic [9:0] x_cnt_i = '0, y_cnt_i = '0, x_pin_i = '0, y_pin_i = '0;
    logic [3:0] glyph_i = '0;
    logic [1:0] color_i = '0;
    logic       hl_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [23:0] a_rgb, b_rgb;
    logic        a_hit, b_hit, a_pv;

    uno_glyph_renderer_if ifa();
    uno_glyph_renderer_if ifb();

    assign ifa.frame_start = fs_i;
    assign ifa.pix_valid_i = pv_i;
    assign ifa.x_cnt       = x_cnt_i;
    assign ifa.y_cnt       = y_cnt_i;
    assign ifa.x_pin       = x_pin_i;
    assign ifa.y_pin       = y_pin_i;
    assign ifa.glyph_sel   = glyph_i;
    assign ifa.color       = card_color_e'(color_i);
    assign ifa.highlight   = hl_i;

    assign ifb.frame_start = fs_i;
    assign ifb.pix_valid_i = pv_i;
    assign ifb.x_cnt       = x_cnt_i;
    assign ifb.y_cnt       = y_cnt_i;
    assign ifb.x_pin       = x_pin_i;
    assign ifb.y_pin       = y_pin_i;
    assign ifb.glyph_sel   = glyph_i;
    assign ifb.color       = card_color_e'(color_i);
    assign ifb.highlight   = hl_i;

    uno_glyph_renderer #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    uno_glyph_renderer #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        fs_i = 1'b1;
        @(negedge clk);
        fs_i = 1'b0;
    endtask

    // One pixel in, result sampled two clocks later.
    task automatic probe(input int x, input int y);
        @(negedge clk);
        pv_i    = 1'b1;
        x_cnt_i = 10'(x);
        y_cnt_i = 10'(y);
        @(negedge clk);
        pv_i = 1'b0;
        @(negedge clk);
        a_rgb = {ifa.r_data, ifa.g_data, ifa.b_data};
        a_hit = ifa.hit;
        a_pv  = ifa.pix_valid_o;
        b_rgb = {ifb.r_data, ifb.g_data, ifb.b_data};
        b_hit = ifb.hit;
        $display("probe (%0d,%0d): A hit=%b rgb=%h  B hit=%b rgb=%h", x, y, a_hit, a_rgb, b_hit, b_rgb);
    endtask

    initial begin
        logic exp_q[$];
        logic exp_bit;
        int   sweep_bad;
        int   hits_seen;
        logic [23:0] exp_rgb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hit", 32'(ifa.hit), 32'd0);
        check("rst_rgb", 32'({ifa.r_data, ifa.g_data, ifa.b_data}), 32'd0);
        check("rst_pv", 32'(ifa.pix_valid_o), 32'd0);
        check("rst_hit_b", 32'(ifb.hit), 32'd0);
        rst = 1'b0;

        // 1: glyph 2, red, at (100,50)
        x_pin_i = 10'd100; y_pin_i = 10'd50; glyph_i = 4'd2; color_i = 2'd0;
        frame_pulse();
        probe(100, 50);
        check("t1_corner_hit", 32'(a_hit), 32'd1);
        check("t1_corner_rgb", 32'(a_rgb), 32'(WHITE));
        check("t1_corner_pv", 32'(a_pv), 32'd1);
        probe(130, 50);
        check("t1_x130_hit", 32'(a_hit), 32'd0);
        check("t1_x130_rgb", 32'(a_rgb), 32'd0);
        check("t1_x130_pv", 32'(a_pv), 32'd1);
        probe(99, 50);
        check("t1_x99_hit", 32'(a_hit), 32'd0);
        probe(129, 99);
        check("t1_far_hit", 32'(a_hit), 32'd1);
        probe(110, 100);
        check("t1_y100_hit", 32'(a_hit), 32'd0);
        probe(110, 56);
        check("t1_red_ink", 32'(a_rgb), 32'(RED_INK));

        // Raster sweep around the box
        exp_q.delete();
        sweep_bad = 0;
        hits_seen = 0;
        for (int y = 45; y <= 104; y++) begin
            for (int x = 95; x <= 135; x++) begin
                @(negedge clk);
                if (exp_q.size() == 2) begin
                    exp_bit = exp_q.pop_front();
                    if (ifa.hit !== exp_bit) sweep_bad++;
                    if (ifa.hit === 1'b1) hits_seen++;
                end
                pv_i    = 1'b1;
                x_cnt_i = 10'(x);
                y_cnt_i = 10'(y);
                exp_q.push_back((x >= 100) && (x < 130) && (y >= 50) && (y < 100));
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            pv_i = 1'b0;
            exp_bit = exp_q.pop_front();
            if (ifa.hit !== exp_bit) sweep_bad++;
            if (ifa.hit === 1'b1) hits_seen++;
        end
        $display("sweep: %0d hits, %0d wrong", hits_seen, sweep_bad);
        check("t1_sweep_wrong", 32'(sweep_bad), 32'd0);
        check("t1_sweep_hits", 32'(hits_seen), 32'd1500);

        // 2: colour variants on an ink pixel
        color_i = 2'd1; frame_pulse(); probe(110, 56);
        check("t2_yellow_ink", 32'(a_rgb), 32'(YEL_INK));
        color_i = 2'd2; frame_pulse(); probe(110, 56);
        check("t2_green_ink", 32'(a_rgb), 32'(GRN_INK));
        color_i = 2'd3; frame_pulse(); probe(110, 56);
        check("t2_blue_ink", 32'(a_rgb), 32'(BLU_INK));
        probe(100, 50);
        check("t2_blue_face", 32'(a_rgb), 32'(WHITE));

        // 3: pin changes take effect only at frame_start
        color_i = 2'd0; frame_pulse();
        x_pin_i = 10'd200;
        probe(100, 50);
        check("t3_old_pos_hit", 32'(a_hit), 32'd1);
        check("t3_old_pos_rgb", 32'(a_rgb), 32'(WHITE));
        probe(200, 50);
        check("t3_new_pos_early", 32'(a_hit), 32'd0);
        frame_pulse();
        probe(200, 50);
        check("t3_new_pos_hit", 32'(a_hit), 32'd1);
        probe(100, 50);
        check("t3_old_pos_gone", 32'(a_hit), 32'd0);

        // Pixel coinciding with frame_start uses the old settings
        x_pin_i = 10'd300; color_i = 2'd3;
        @(negedge clk);
        fs_i = 1'b1; pv_i = 1'b1; x_cnt_i = 10'd210; y_cnt_i = 10'd56;
        @(negedge clk);
        fs_i = 1'b0; pv_i = 1'b0;
        @(negedge clk);
        check("t3_same_cycle_hit", 32'(ifa.hit), 32'd1);
        check("t3_same_cycle_rgb", 32'({ifa.r_data, ifa.g_data, ifa.b_data}), 32'(RED_INK));
        probe(210, 56);
        check("t3_after_hit", 32'(a_hit), 32'd0);
        probe(310, 56);
        check("t3_after_rgb", 32'(a_rgb), 32'(BLU_INK));

        // 4: 2x scale near the right edge (instance B)
        x_pin_i = 10'd1000; y_pin_i = 10'd0; color_i = 2'd0;
        frame_pulse();
        probe(1023, 0);
        check("t4_clip_hit", 32'(b_hit), 32'd1);
        check("t4_clip_rgb", 32'(b_rgb), 32'(WHITE));
        hits_seen = 0;
        for (int x = 0; x <= 40; x++) begin
            @(negedge clk);
            if (ifb.hit === 1'b1) hits_seen++;
            pv_i = 1'b1; x_cnt_i = 10'(x); y_cnt_i = 10'd0;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            pv_i = 1'b0;
            if (ifb.hit === 1'b1) hits_seen++;
        end
        check("t4_no_wrap", 32'(hits_seen), 32'd0);
        probe(1014, 12);
        check("t4_ink_a", 32'(b_rgb), 32'(RED_INK));
        probe(1015, 13);
        check("t4_ink_b", 32'(b_rgb), 32'(RED_INK));
        probe(1013, 12);
        check("t4_face_left", 32'(b_rgb), 32'(WHITE));
        probe(1014, 9);
        check("t4_face_above", 32'(b_rgb), 32'(WHITE));
        probe(1014, 10);
        check("t4_ink_top", 32'(b_rgb), 32'(RED_INK));

        // 5: highlight blink, BLINK_FRAMES=2
        x_pin_i = 10'd100; y_pin_i = 10'd50; hl_i = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            frame_pulse();
            exp_rgb = (BLINK_ON && (f == 3 || f == 4)) ? WHITE : RED_INK;
            probe(110, 56);
            check($sformatf("t5_ink_f%0d", f), 32'(a_rgb), 32'(exp_rgb));
            exp_rgb = (BLINK_ON && (f == 3 || f == 4)) ? RED_INK : WHITE;
            probe(100, 50);
            check($sformatf("t5_face_f%0d", f), 32'(a_rgb), 32'(exp_rgb));
        end
        frame_pulse();
        frame_pulse();
        hl_i = 1'b0;
        frame_pulse();
        probe(110, 56);
        check("t5_drop_hl", 32'(a_rgb), 32'(RED_INK));

        // 6: out-of-range glyph and mid-line reset
        glyph_i = 4'd12;
        frame_pulse();
        probe(110, 56);
        check("t6_blank_hit", 32'(a_hit), 32'd1);
        check("t6_blank_rgb", 32'(a_rgb), 32'(WHITE));
        for (int x = 110; x <= 112; x++) begin
            @(negedge clk);
            pv_i = 1'b1; x_cnt_i = 10'(x); y_cnt_i = 10'd56;
        end
        @(negedge clk);
        check("t6_pre_rst_hit", 32'(ifa.hit), 32'd1);
        rst = 1'b1;
        x_cnt_i = 10'd113;
        @(negedge clk);
        check("t6_rst_hit", 32'(ifa.hit), 32'd0);
        check("t6_rst_rgb", 32'({ifa.r_data, ifa.g_data, ifa.b_data}), 32'd0);
        check("t6_rst_pv", 32'(ifa.pix_valid_o), 32'd0);
        rst = 1'b0;
        pv_i = 1'b0;
        // Shadows back at pin (0,0), glyph 0, red
        probe(0, 0);
        check("t6_reset_pin_hit", 32'(a_hit), 32'd1);
        check("t6_reset_face", 32'(a_rgb), 32'(WHITE));
        probe(7, 6);
        check("t6_reset_glyph0", 32'(a_rgb), 32'(RED_INK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
